// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier sequencer: FSM state encoding and operand width.
package mult_pkg;
  localparam int MULT_WIDTH = 8;

  typedef enum logic [2:0] {IDLE, CLR, ADD, SHIFT, HOLD} state_t;
endpackage

// File: rtl/multiplier_control.sv
// Sequencer for the signed shift-add multiplier: one CLR, then WIDTH add/shift pairs, then HOLD
// until Run is released so that a held Run yields exactly one multiply.
module multiplier_control
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic M,
  output logic Ld_B,
  output logic Clr_XA,
  output logic Ld_XA,
  output logic Sub,
  output logic Shift_En,
  output logic Busy,
  output logic Done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    Ld_B     = 1'b0;
    Clr_XA   = 1'b0;
    Ld_XA    = 1'b0;
    Sub      = 1'b0;
    Shift_En = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Operand load wins over a start request in the same cycle.
        if (ClearA_LoadB) begin
          Ld_B   = 1'b1;
          Clr_XA = 1'b1;
        end else if (Run) begin
          state_d = CLR;
          cnt_d   = '0;
        end
      end
      CLR: begin
        Clr_XA  = 1'b1;
        Busy    = 1'b1;
        state_d = ADD;
      end
      ADD: begin
        // The sign bit of a two's-complement multiplier carries negative weight.
        Busy    = 1'b1;
        Ld_XA   = M;
        Sub     = M && (cnt_q == LAST);
        state_d = SHIFT;
      end
      SHIFT: begin
        Busy     = 1'b1;
        Shift_En = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        state_d  = (cnt_q == LAST) ? HOLD : ADD;
      end
      HOLD: begin
        Done = 1'b1;
        if (!Run) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_multiplier_control.sv
// Bench for multiplier_control: fixed vector table, hand-built multi-cycle sequences and
// random stimulus compared each cycle against a cycle-offset reference model.
module tb_multiplier_control;
  localparam int W = 8;

  logic Clk = 1'b0;
  logic Reset, Run, ClearA_LoadB, M;
  logic Ld_B, Clr_XA, Ld_XA, Sub, Shift_En, Busy, Done;
  logic [6:0] dut_out, last_out;

  int total = 0;
  int bad = 0;
  // -1 idle, 0 clear, 1..2W add/shift (odd = add of iteration (p-1)/2), 2W+1 hold
  int mph = -1;

  multiplier_control #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .M(M),
    .Ld_B(Ld_B), .Clr_XA(Clr_XA), .Ld_XA(Ld_XA), .Sub(Sub), .Shift_En(Shift_En),
    .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;
  assign dut_out = {Ld_B, Clr_XA, Ld_XA, Sub, Shift_En, Busy, Done};

  typedef struct packed {
    logic       rst, run, clb, m;
    logic [6:0] exp_o;
  } vec_t;

  // Output bit order: Ld_B Clr_XA Ld_XA Sub Shift_En Busy Done
  function automatic logic [6:0] model_out(int ph, logic clb, logic m);
    logic [6:0] o;
    o = '0;
    if (ph < 0) begin
      o[6] = clb;
      o[5] = clb;
    end else if (ph == 0) begin
      o[5] = 1'b1;
      o[1] = 1'b1;
    end else if (ph <= 2 * W) begin
      o[1] = 1'b1;
      if (ph % 2 == 1) begin
        o[4] = m;
        o[3] = m && ((ph - 1) / 2 == W - 1);
      end else begin
        o[2] = 1'b1;
      end
    end else begin
      o[0] = 1'b1;
    end
    return o;
  endfunction

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic cycle(input logic rst, input logic run, input logic clb, input logic m);
    logic [6:0] exp_o;
    Reset = rst; Run = run; ClearA_LoadB = clb; M = m;
    @(negedge Clk);
    exp_o = model_out(mph, clb, m);
    last_out = dut_out;
    check("model", int'(last_out), int'(exp_o));
    @(posedge Clk);
    if (rst) mph = -1;
    else if (mph < 0) begin
      if (!clb && run) mph = 0;
    end else if (mph <= 2 * W) mph++;
    else if (!run) mph = -1;
    #1;
  endtask

  task automatic do_mult(input logic [W-1:0] b, input int hold, input int clb_iter);
    int shifts, subs, lds, busy_n, clr_n, done_n, done_at, k;
    logic m, clb;
    shifts = 0; subs = 0; lds = 0; busy_n = 0; clr_n = 0; done_n = 0; done_at = -1;
    for (k = 0; k < 120; k++) begin
      m = 1'(($urandom));
      if (mph > 0 && mph <= 2 * W && (mph % 2 == 1)) m = b[(mph - 1) / 2];
      clb = (clb_iter >= 0) && (mph == 2 * clb_iter + 1 || mph == 2 * clb_iter + 2);
      cycle(1'b0, k < hold, clb, m);
      shifts += int'(last_out[2]);
      subs   += int'(last_out[3]);
      lds    += int'(last_out[4]);
      busy_n += int'(last_out[1]);
      clr_n  += int'(last_out[5] && last_out[1]);
      done_n += int'(last_out[0]);
      if (last_out[0] && done_at < 0) done_at = k;
      if (k > 0 && mph < 0) break;
    end
    if (k >= 120) check("mult_timeout", k, 0);
    check("shift_pulses", shifts, W);
    check("sub_pulses", subs, int'(b[W-1]));
    check("ldxa_pulses", lds, $countones(b));
    check("busy_cycles", busy_n, 1 + 2 * W);
    check("clr_count", clr_n, 1);
    check("done_cycle", done_at, 2 * W + 2);
    check("done_len", done_n, ((hold > 2 * W + 2) ? hold : 2 * W + 2) - (2 * W + 2) + 1);
  endtask

  vec_t tbl[9];

  initial begin
    int k;
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 7'b0000000};  // third reset cycle, Run high
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 7'b0000000};  // IDLE samples Run
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 7'b0100010};  // CLR
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 7'b0010010};  // ADD iter 0, M=1
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 7'b0000110};  // SHIFT
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 7'b0000010};  // ADD iter 1, M=0, reset applied
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 7'b1100000};  // IDLE load
    tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 7'b1100000};  // load beats Run
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000};  // still IDLE

    Reset = 1'b1; Run = 1'b1; ClearA_LoadB = 1'b0; M = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    mph = -1;

    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].rst, tbl[i].run, tbl[i].clb, tbl[i].m);
      check($sformatf("table[%0d]", i), int'(last_out), int'(tbl[i].exp_o));
    end

    do_mult(8'h07, 20, -1);
    do_mult(8'h80, 20, -1);
    do_mult(8'hA5, 40, -1);
    do_mult(8'h3C, 19, 3);

    // Reset during SHIFT of iteration 4 aborts straight to IDLE.
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    for (k = 0; k < 40 && mph != 2 * 4 + 2; k++) cycle(1'b0, 1'b1, 1'b0, 1'b1);
    check("reach_iter4_shift", mph, 2 * 4 + 2);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("abort_in_shift", int'(last_out), 7'b0000110);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("post_reset_idle", int'(last_out), 0);
    do_mult(8'hFF, 20, -1);

    for (int i = 0; i < 12; i++)
      do_mult(W'($urandom), 1 + int'($urandom_range(0, 30)),
              int'($urandom_range(0, 9)) - 1);

    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 19) == 0, 1'($urandom), $urandom_range(0, 3) == 0, 1'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
